// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter with burst lock for the write port of an async FIFO.
// The owner keeps the port until it sends last or MAX_BURST beats have gone through.
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                          a_clk_i,
    input  logic                          aresetn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic                          grant_vld_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {S_IDLE, S_BURST} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            found;
    logic [IDW-1:0]  pick;
    logic            xfer;
    logic            owner_valid;
    logic            owner_last;
    logic [DATA_WIDTH-1:0] owner_data;

    // Owner-side view of the requester bus.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDW'(k)) begin
                owner_valid = req_valid_i[k];
                owner_last  = req_last_i[k];
                owner_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant_q) + i) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        xfer         = 1'b0;
        fifo_wr_en_o = 1'b0;
        fifo_data_o  = '0;
        req_ready_o  = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d      = pick;
                    last_grant_d = pick;
                    beat_cnt_d   = '0;
                    state_d      = S_BURST;
                end
            end
            S_BURST: begin
                xfer         = owner_valid & ~fifo_full_i;
                fifo_wr_en_o = xfer;
                fifo_data_o  = owner_data;
                for (int k = 0; k < NUM_REQ; k++) begin
                    req_ready_o[k] = xfer && (owner_q == IDW'(k));
                end
                // Burst only ends on a beat that actually transferred.
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (owner_last || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge a_clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign grant_vld_o = (state_q == S_BURST);
    assign grant_id_o  = owner_q;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Bench for async_fifo_wr_arbiter: per-requester source queues, hand-ordered
// expected write queue, and a negedge monitor that pops and compares each write.
module tb_async_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic                 a_clk_i;
    logic                 aresetn_i   = 1'b1;
    logic [NREQ-1:0]      req_valid_i = '0;
    logic [NREQ-1:0]      req_last_i  = '0;
    logic [NREQ*DW-1:0]   req_data_i  = '0;
    logic [NREQ-1:0]      req_ready_o;
    logic                 fifo_full_i = 1'b0;
    logic                 fifo_wr_en_o;
    logic [DW-1:0]        fifo_data_o;
    logic                 grant_vld_o;
    logic [IDW-1:0]       grant_id_o;

    int checks   = 0;
    int failures = 0;

    logic [IDW+DW-1:0] exp_q[$];
    logic [DW:0]       src_q[NREQ][$];
    logic [NREQ-1:0]   acc;

    async_fifo_wr_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
        .a_clk_i      (a_clk_i),
        .aresetn_i    (aresetn_i),
        .req_valid_i  (req_valid_i),
        .req_last_i   (req_last_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_data_o  (fifo_data_o),
        .grant_vld_o  (grant_vld_o),
        .grant_id_o   (grant_id_o)
    );

    // Clock and reset
    initial a_clk_i = 1'b0;
    always #5 a_clk_i = ~a_clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic load(input int id, input logic [DW-1:0] base, input int n, input bit last_on_end);
        for (int i = 0; i < n; i++) begin
            src_q[id].push_back({last_on_end && (i == n - 1), base + DW'(i)});
        end
    endtask

    task automatic ex(input int id, input logic [DW-1:0] d);
        exp_q.push_back({IDW'(id), d});
    endtask

    function automatic bit src_busy();
        bit b = 1'b0;
        for (int k = 0; k < NREQ; k++) if (src_q[k].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drive();
        logic [DW:0] h;
        for (int k = 0; k < NREQ; k++) begin
            if (src_q[k].size() > 0) begin
                h = src_q[k][0];
                req_valid_i[k] = 1'b1;
                req_last_i[k]  = h[DW];
                req_data_i[k*DW +: DW] = h[DW-1:0];
            end else begin
                req_valid_i[k] = 1'b0;
                req_last_i[k]  = 1'b0;
                req_data_i[k*DW +: DW] = '0;
            end
        end
    endtask

    // Producers: a beat leaves its source queue once it was accepted.
    always begin
        @(negedge a_clk_i);
        acc = req_ready_o;
        @(posedge a_clk_i);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        end
        drive();
    end

    // Scoreboard monitor
    always @(negedge a_clk_i) begin
        logic [IDW+DW-1:0] e;
        logic [NREQ-1:0]   rdy_exp;
        chk("wr_while_full", 64'(fifo_wr_en_o & fifo_full_i), 64'd0);
        rdy_exp = fifo_wr_en_o ? (NREQ'(1) << grant_id_o) : '0;
        chk("ready_onehot", 64'(req_ready_o), 64'(rdy_exp));
        if (fifo_wr_en_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h expected=none", {grant_id_o, fifo_data_o});
            end else begin
                e = exp_q.pop_front();
                chk("write", 64'({grant_id_o, fifo_data_o}), 64'(e));
            end
        end
    end

    task automatic chk_idle_outputs(input string name);
        chk({name, "_gv"},   64'(grant_vld_o),  64'd0);
        chk({name, "_wr"},   64'(fifo_wr_en_o), 64'd0);
        chk({name, "_rdy"},  64'(req_ready_o),  64'd0);
        chk({name, "_data"}, 64'(fifo_data_o),  64'd0);
        chk({name, "_id"},   64'(grant_id_o),   64'd0);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        do begin
            @(negedge a_clk_i);
            n++;
        end while ((exp_q.size() != 0 || src_busy() || grant_vld_o) && n < 300);
        chk({name, "_drain_timeout"}, 64'(n >= 300), 64'd0);
    endtask

    task automatic wait_wr(output int n);
        n = 0;
        do begin
            @(negedge a_clk_i);
            n++;
        end while (!fifo_wr_en_o && n < 50);
        chk("wait_wr_timeout", 64'(n >= 50), 64'd0);
    endtask

    initial begin
        int n, total;
        #2 aresetn_i = 1'b0;
        @(negedge a_clk_i);
        chk_idle_outputs("in_reset");
        @(posedge a_clk_i); #1 aresetn_i = 1'b1;
        @(negedge a_clk_i);
        chk_idle_outputs("after_reset");

        // Requesters 0 and 2 each offer three single-beat bursts: 0,2,0,2,0,2.
        for (int i = 0; i < 3; i++) begin
            load(0, 32'hA000_0000 + DW'(i), 1, 1'b1);
            load(2, 32'hB000_0000 + DW'(i), 1, 1'b1);
            ex(0, 32'hA000_0000 + DW'(i));
            ex(2, 32'hB000_0000 + DW'(i));
        end
        @(negedge a_clk_i);
        chk("rr_gv_before", 64'(grant_vld_o), 64'd0);
        @(negedge a_clk_i);
        chk("rr_gv_rise", 64'(grant_vld_o), 64'd1);
        chk("rr_first_id", 64'(grant_id_o), 64'd0);
        wait_drain("rr");

        // Requester 1: three beats, last on the third, back to back.
        load(1, 32'hD000_0000, 3, 1'b1);
        for (int i = 0; i < 3; i++) ex(1, 32'hD000_0000 + DW'(i));
        @(negedge a_clk_i);
        chk("b3_arb_cycle_wr", 64'(fifo_wr_en_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge a_clk_i);
            chk("b3_wr_consecutive", 64'(fifo_wr_en_o), 64'd1);
        end
        @(negedge a_clk_i);
        chk("b3_back_to_idle", 64'(grant_vld_o), 64'd0);
        wait_drain("b3");

        // Requester 3: 12 beats, cut after 8; requester 1 slips in between.
        load(3, 32'hE000_0000, 12, 1'b1);
        load(1, 32'hF000_0000, 1, 1'b1);
        for (int i = 0; i < 8; i++) ex(3, 32'hE000_0000 + DW'(i));
        ex(1, 32'hF000_0000);
        for (int i = 8; i < 12; i++) ex(3, 32'hE000_0000 + DW'(i));
        wait_drain("maxburst");

        // Requester 0: 5 beats, FIFO full for 5 cycles before beat 2.
        load(0, 32'h6000_0000, 5, 1'b1);
        for (int i = 0; i < 5; i++) ex(0, 32'h6000_0000 + DW'(i));
        repeat (3) @(negedge a_clk_i);
        @(posedge a_clk_i); #1 fifo_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge a_clk_i);
            chk("stall_wr",  64'(fifo_wr_en_o), 64'd0);
            chk("stall_rdy", 64'(req_ready_o),  64'd0);
            chk("stall_gv",  64'(grant_vld_o),  64'd1);
            chk("stall_id",  64'(grant_id_o),   64'd0);
        end
        @(posedge a_clk_i); #1 fifo_full_i = 1'b0;
        wait_drain("stall");

        // Fresh reset, then all four with single-beat bursts: 0,1,2,3,0,1,2,3.
        @(posedge a_clk_i); #1 aresetn_i = 1'b0;
        @(negedge a_clk_i);
        chk_idle_outputs("reset2");
        @(posedge a_clk_i); #1 aresetn_i = 1'b1;
        @(negedge a_clk_i);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NREQ; k++) begin
                load(k, 32'h7000_0000 + DW'(r * 16 + k), 1, 1'b1);
                ex(k, 32'h7000_0000 + DW'(r * 16 + k));
            end
        end
        wait_wr(n);
        chk("all4_first_wr_latency", 64'(n), 64'd2);
        total = 0;
        for (int i = 0; i < 4; i++) begin
            wait_wr(n);
            total += n;
        end
        chk("all4_req0_period", 64'(total), 64'd8);
        wait_drain("all4");

        // Requester 2: reset lands while beat 1 of 4 is on the port.
        load(2, 32'h9000_0000, 4, 1'b1);
        for (int i = 0; i < 4; i++) ex(2, 32'h9000_0000 + DW'(i));
        repeat (2) @(negedge a_clk_i);
        @(posedge a_clk_i); #1 aresetn_i = 1'b0;
        @(negedge a_clk_i);
        chk_idle_outputs("midburst_reset");
        @(posedge a_clk_i); #1 aresetn_i = 1'b1;
        @(negedge a_clk_i);
        chk("regrant_arb_gv", 64'(grant_vld_o), 64'd0);
        @(negedge a_clk_i);
        chk("regrant_gv", 64'(grant_vld_o), 64'd1);
        chk("regrant_id", 64'(grant_id_o), 64'd2);
        wait_drain("regrant");

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
